// File: rtl/craps_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : craps_roll_ctrl
// Purpose  : Dice-roll controller for the craps outcome logic. It generates
//            two dice from an LFSR or from forced values and presents their
//            sum. It then samples the returned outcome code, tracks the point
//            and keeps saturating win/loss tallies.
// Revision : 1.0 - initial release
// ============================================================================
module craps_roll_ctrl #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             roll,
   input  logic             force_en,
   input  logic [2:0]       force_d1,
   input  logic [2:0]       force_d2,
   input  logic [1:0]       op,
   output logic [2:0]       die1,
   output logic [2:0]       die2,
   output logic [3:0]       sum,
   output logic [3:0]       point,
   output logic             sum_valid,
   output logic             game_clr,
   output logic             busy,
   output logic             round_done,
   output logic             round_win,
   output logic [CNT_W-1:0] wins,
   output logic [CNT_W-1:0] losses
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GEN     = 3'd1,
      PRESENT = 3'd2,
      EVAL    = 3'd3,
      UPDATE  = 3'd4
   } state_t;

   localparam logic [1:0]       OP_REROLL = 2'b01;
   localparam logic [1:0]       OP_WIN    = 2'b10;
   localparam logic [1:0]       OP_LOSE   = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             f_en_q, f_en_d;
   logic [2:0]       f_d1_q, f_d1_d;
   logic [2:0]       f_d2_q, f_d2_d;
   logic [2:0]       die1_q, die1_d;
   logic [2:0]       die2_q, die2_d;
   logic [3:0]       sum_q, sum_d;
   logic [3:0]       point_q, point_d;
   logic [1:0]       res_q, res_d;
   logic             round_win_q, round_win_d;
   logic [CNT_W-1:0] wins_q, wins_d;
   logic [CNT_W-1:0] losses_q, losses_d;

   logic [2:0]       cand1, cand2;
   logic             cand_ok;

   // LFSR free-runs every cycle; taps 16,14,13,11 (x^16+x^14+x^13+x^11+1)
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Candidate dice for this cycle: forced values win, else LFSR bits that
   // must both fall in 1..6 to be accepted
   always_comb begin
      cand1   = lfsr_q[2:0];
      cand2   = lfsr_q[5:3];
      cand_ok = 1'b0;
      if (f_en_q) begin
         cand1   = f_d1_q;
         cand2   = f_d2_q;
         cand_ok = 1'b1;
      end else begin
         cand_ok = (cand1 != 3'd0) && (cand1 != 3'd7) &&
                   (cand2 != 3'd0) && (cand2 != 3'd7);
      end
   end

   // Next-state and datapath updates for the roll sequence
   always_comb begin
      state_d     = state_q;
      f_en_d      = f_en_q;
      f_d1_d      = f_d1_q;
      f_d2_d      = f_d2_q;
      die1_d      = die1_q;
      die2_d      = die2_q;
      sum_d       = sum_q;
      point_d     = point_q;
      res_d       = res_q;
      round_win_d = round_win_q;
      wins_d      = wins_q;
      losses_d    = losses_q;

      case (state_q)
         IDLE: begin
            if (roll) begin
               f_en_d  = force_en;
               f_d1_d  = force_d1;
               f_d2_d  = force_d2;
               state_d = GEN;
            end
         end
         GEN: begin
            if (cand_ok) begin
               die1_d  = cand1;
               die2_d  = cand2;
               sum_d   = {1'b0, cand1} + {1'b0, cand2};
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            state_d = EVAL;
         end
         EVAL: begin
            res_d   = op;
            state_d = UPDATE;
         end
         UPDATE: begin
            case (res_q)
               OP_REROLL: begin
                  if (point_q == 4'd0) begin
                     point_d = sum_q;
                  end
               end
               OP_WIN: begin
                  if (wins_q != CNT_MAX) begin
                     wins_d = wins_q + CNT_ONE;
                  end
                  round_win_d = 1'b1;
                  point_d     = 4'd0;
               end
               OP_LOSE: begin
                  if (losses_q != CNT_MAX) begin
                     losses_d = losses_q + CNT_ONE;
                  end
                  round_win_d = 1'b0;
                  point_d     = 4'd0;
               end
               default: begin
                  // init code here is a protocol error from the outcome logic
               end
            endcase
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         f_en_q      <= 1'b0;
         f_d1_q      <= 3'd0;
         f_d2_q      <= 3'd0;
         die1_q      <= 3'd0;
         die2_q      <= 3'd0;
         sum_q       <= 4'd0;
         point_q     <= 4'd0;
         res_q       <= 2'b00;
         round_win_q <= 1'b0;
         wins_q      <= {CNT_W{1'b0}};
         losses_q    <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         f_en_q      <= f_en_d;
         f_d1_q      <= f_d1_d;
         f_d2_q      <= f_d2_d;
         die1_q      <= die1_d;
         die2_q      <= die2_d;
         sum_q       <= sum_d;
         point_q     <= point_d;
         res_q       <= res_d;
         round_win_q <= round_win_d;
         wins_q      <= wins_d;
         losses_q    <= losses_d;
      end
   end

   // Pulses decode directly from state so they last exactly one cycle
   always_comb begin
      sum_valid  = (state_q == PRESENT);
      busy       = (state_q != IDLE);
      round_done = (state_q == UPDATE) && res_q[1];
      game_clr   = (state_q == UPDATE) && res_q[1];
   end

   assign die1      = die1_q;
   assign die2      = die2_q;
   assign sum       = sum_q;
   assign point     = point_q;
   assign round_win = round_win_q;
   assign wins      = wins_q;
   assign losses    = losses_q;

endmodule
`default_nettype wire

// File: tb/tb_craps_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_craps_roll_ctrl
// Purpose  : Self-checking bench for craps_roll_ctrl against a game-level
//            reference model (point, tallies, dice acceptance, pulse timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_craps_roll_ctrl;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset;
   logic       roll;
   logic       force_en;
   logic [2:0] force_d1, force_d2;
   logic [1:0] op;
   logic [2:0] die1, die2;
   logic [3:0] sum, point;
   logic       sum_valid, game_clr, busy, round_done, round_win;
   logic [7:0] wins, losses;

   logic       op_auto;
   logic [1:0] op_fixed;
   logic [15:0] ref_lfsr;

   int n_checks = 0;
   int n_fail   = 0;

   // reference game state
   int m_point, m_wins, m_losses, m_round_win;

   craps_roll_ctrl #(.SEED(SEED), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .roll(roll), .force_en(force_en),
      .force_d1(force_d1), .force_d2(force_d2), .op(op),
      .die1(die1), .die2(die2), .sum(sum), .point(point),
      .sum_valid(sum_valid), .game_clr(game_clr), .busy(busy),
      .round_done(round_done), .round_win(round_win),
      .wins(wins), .losses(losses)
   );

   always #5 clk = ~clk;

   // Craps outcome rules: come-out 7/11 win, 2/3/12 lose; then point wins, 7 loses
   function automatic logic [1:0] craps_op(input int s, input int p);
      if (p == 0) begin
         if (s == 7 || s == 11) return 2'b10;
         if (s == 2 || s == 3 || s == 12) return 2'b11;
         return 2'b01;
      end
      if (s == p) return 2'b10;
      if (s == 7) return 2'b11;
      return 2'b01;
   endfunction

   // Outcome-logic stand-in: either a fixed code or the real game rules
   always_comb begin
      op = op_auto ? craps_op(int'(sum), int'(point)) : op_fixed;
   end

   // Reference LFSR sequence from SEED (polynomial x^16+x^14+x^13+x^11+1)
   always @(posedge clk) begin
      if (reset) ref_lfsr <= SEED;
      else       ref_lfsr <= {ref_lfsr[14:0],
                              ^(ref_lfsr & 16'b1011_0100_0000_0000)};
   end

   task automatic model_clear();
      m_point = 0; m_wins = 0; m_losses = 0; m_round_win = 0;
   endtask

   // One roll from IDLE; called at a sample point (1 time unit after posedge)
   task automatic do_roll(input bit fen, input int d1, input int d2,
                          input logic [1:0] opv, input bit use_auto, input bit hammer);
      int  k = -1, sv_cnt = 0, sv_idx = -1, rd_cnt = 0, rd_idx = -1, gc_cnt = 0;
      int  done_idx = -1, ed1 = 0, ed2 = 0, es, c1, c2;
      logic [1:0] eo;
      force_en = fen; force_d1 = 3'(d1); force_d2 = 3'(d2);
      op_fixed = opv; op_auto = use_auto; roll = 1'b1;
      @(posedge clk); #1;
      roll = hammer;
      force_en = 1'($urandom_range(0, 1));
      force_d1 = 3'($urandom_range(1, 6));
      force_d2 = 3'($urandom_range(1, 6));
      for (int i = 0; i < 80 && done_idx < 0; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (k < 0) begin
            if (fen) begin
               k = i; ed1 = d1; ed2 = d2;
            end else begin
               c1 = int'(ref_lfsr[2:0]); c2 = int'(ref_lfsr[5:3]);
               if (c1 >= 1 && c1 <= 6 && c2 >= 1 && c2 <= 6) begin
                  k = i; ed1 = c1; ed2 = c2;
               end
            end
         end
         if (sum_valid)  begin sv_cnt++; sv_idx = i; end
         if (round_done) begin rd_cnt++; rd_idx = i; end
         if (game_clr)   gc_cnt++;
         if (hammer && i >= 3) roll = 1'b0;
         if (!busy) done_idx = i;
      end
      roll = 1'b0;
      n_checks++;
      if (done_idx < 0 || k < 0) begin
         n_fail++;
         $display("FAIL roll_timeout: busy never dropped (accept idx %0d), required return to IDLE", k);
         return;
      end
      es = ed1 + ed2;
      eo = use_auto ? craps_op(es, m_point) : opv;
      if (eo == 2'b01 && m_point == 0) m_point = es;
      if (eo == 2'b10) begin if (m_wins < 255) m_wins++; m_round_win = 1; m_point = 0; end
      if (eo == 2'b11) begin if (m_losses < 255) m_losses++; m_round_win = 0; m_point = 0; end

      n_checks++; if (int'(die1) != ed1 || int'(die2) != ed2) begin n_fail++;
         $display("FAIL dice: got %0d+%0d, required %0d+%0d", die1, die2, ed1, ed2); end
      n_checks++; if (die1 < 1 || die1 > 6 || die2 < 1 || die2 > 6) begin n_fail++;
         $display("FAIL dice_range: got %0d,%0d, required 1..6", die1, die2); end
      n_checks++; if (int'(sum) != es) begin n_fail++;
         $display("FAIL sum: got %0d, required %0d", sum, es); end
      n_checks++; if (sv_cnt != 1 || sv_idx != k + 1) begin n_fail++;
         $display("FAIL sum_valid: got %0d pulses at idx %0d, required 1 at idx %0d", sv_cnt, sv_idx, k + 1); end
      n_checks++;
      if (eo[1] ? (rd_cnt != 1 || rd_idx != k + 3 || gc_cnt != 1) : (rd_cnt != 0 || gc_cnt != 0)) begin
         n_fail++;
         $display("FAIL round_done: got %0d pulses at idx %0d (game_clr %0d), required %0d at idx %0d",
                  rd_cnt, rd_idx, gc_cnt, eo[1] ? 1 : 0, k + 3);
      end
      n_checks++; if (done_idx != k + 4) begin n_fail++;
         $display("FAIL latency: idle at idx %0d, required %0d", done_idx, k + 4); end
      n_checks++; if (int'(point) != m_point) begin n_fail++;
         $display("FAIL point: got %0d, required %0d", point, m_point); end
      n_checks++; if (int'(wins) != m_wins || int'(losses) != m_losses) begin n_fail++;
         $display("FAIL tallies: got w%0d l%0d, required w%0d l%0d", wins, losses, m_wins, m_losses); end
      n_checks++; if (int'(round_win) != m_round_win) begin n_fail++;
         $display("FAIL round_win: got %0d, required %0d", round_win, m_round_win); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      n_checks++;
      if ({die1, die2, sum, point, sum_valid, game_clr, busy, round_done, round_win, wins, losses} !== '0) begin
         n_fail++;
         $display("FAIL reset_initial: outputs not all zero (sum %0d busy %0b wins %0d)", sum, busy, wins);
      end
      // get a point latched, then abort a roll in GEN
      do_roll(1'b1, 2, 2, 2'b01, 1'b0, 1'b0);
      force_en = 1'b1; force_d1 = 3'd3; force_d2 = 3'd4; op_fixed = 2'b10; op_auto = 1'b0;
      roll = 1'b1;
      @(posedge clk); #1;
      roll = 1'b0; reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      n_checks++;
      if ({die1, die2, sum, point, sum_valid, game_clr, busy, round_done, round_win, wins, losses} !== '0) begin
         n_fail++;
         $display("FAIL reset_midroll: got sum %0d point %0d busy %0b wins %0d, required all zero", sum, point, busy, wins);
      end
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || round_done !== 1'b0 || wins !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_after: busy %0b round_done %0b wins %0d, required 0/0/0", busy, round_done, wins);
      end
   endtask

   task automatic test_natural_win();
      do_roll(1'b1, 3, 4, 2'b10, 1'b0, 1'b0);
   endtask

   task automatic test_point_win();
      do_roll(1'b1, 2, 2, 2'b01, 1'b0, 1'b0);
      do_roll(1'b1, 1, 5, 2'b01, 1'b0, 1'b0);
      do_roll(1'b1, 3, 1, 2'b10, 1'b0, 1'b0);
   endtask

   task automatic test_seven_out();
      do_roll(1'b1, 5, 5, 2'b01, 1'b0, 1'b0);
      do_roll(1'b1, 6, 1, 2'b11, 1'b0, 1'b0);
   endtask

   task automatic test_protocol_error();
      do_roll(1'b1, 4, 4, 2'b01, 1'b0, 1'b0);
      do_roll(1'b1, 6, 6, 2'b00, 1'b0, 1'b0);
      do_roll(1'b1, 4, 4, 2'b10, 1'b0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      for (int i = 0; i < 4; i++)
         do_roll(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                 2'($urandom_range(1, 3)), 1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++)
         do_roll(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 2'b10, 1'b0, 1'b0);
      n_checks++;
      if (wins !== 8'd255) begin
         n_fail++;
         $display("FAIL wins_saturate: got %0d, required 255", wins);
      end
   endtask

   task automatic test_lfsr();
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         do_roll(1'b0, 0, 0, 2'b00, 1'b1, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; roll = 1'b0; force_en = 1'b0; force_d1 = 3'd1; force_d2 = 3'd1;
      op_auto = 1'b0; op_fixed = 2'b00;
      model_clear();
      test_reset();
      test_natural_win();
      test_point_win();
      test_seven_out();
      test_protocol_error();
      test_busy_ignore();
      test_saturation();
      test_lfsr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
